// File: rtl/gpr_access_arbiter_if.sv
// Signal bundle linking the two GPR requesters and the register file to the arbiter.
// The arbiter connects to the slave modport; the requester/GPR environment uses master.
interface gpr_access_arbiter_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
);
  logic              a_req;
  logic              a_we;
  logic [3:0]        a_idx;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [3:0]        b_idx;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              b_err;

  logic [ADDR_W-1:0] gpr_address;
  logic              gpr_rd;
  logic              gpr_wr;
  logic [DATA_W-1:0] gpr_wdata;
  logic              gpr_data_oe;
  logic [DATA_W-1:0] gpr_rdata;

  modport slave (
    input  a_req, a_we, a_idx, a_wdata,
    input  b_req, b_we, b_idx, b_wdata,
    input  gpr_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output gpr_address, gpr_rd, gpr_wr, gpr_wdata, gpr_data_oe
  );

  modport master (
    output a_req, a_we, a_idx, a_wdata,
    output b_req, b_we, b_idx, b_wdata,
    output gpr_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  gpr_address, gpr_rd, gpr_wr, gpr_wdata, gpr_data_oe
  );
endinterface

// File: rtl/gpr_access_arbiter.sv
// Two-port round-robin arbiter serialising accesses to the 16-entry GPR file,
// with FLAGS write protection against port B. Every output comes from a flop.
module gpr_access_arbiter #(
  parameter int DATA_W    = 14,
  parameter int ADDR_W    = 12,
  parameter int FLAGS_IDX = 8
) (
  input logic                clk,
  input logic                rst,
  gpr_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;      // port granted last: 1 = B
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d, b_err_q, b_err_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
  logic [3:0]        addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              win;
  logic              win_we;
  logic [3:0]        win_idx;
  logic [DATA_W-1:0] win_wdata;
  logic              win_prot;

  // A lone requester wins outright; on a tie the port not granted last wins.
  assign win       = (bus.a_req && bus.b_req) ? ~rr_q : bus.b_req;
  assign win_we    = win ? bus.b_we    : bus.a_we;
  assign win_idx   = win ? bus.b_idx   : bus.a_idx;
  assign win_wdata = win ? bus.b_wdata : bus.a_wdata;
  assign win_prot  = win && win_we && (win_idx == 4'(FLAGS_IDX));

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    port_d     = port_q;
    we_d       = we_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    b_err_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    oe_d       = 1'b0;
    addr_d     = '0;
    wdata_d    = '0;
    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          state_d = ISSUE;
          rr_d    = win;
          port_d  = win;
          we_d    = win_we;
          a_gnt_d = ~win;
          b_gnt_d = win;
          addr_d  = win_idx;
          if (!win_we) begin
            rd_d = 1'b1;
          end else if (win_prot) begin
            b_err_d = 1'b1;
          end else begin
            wr_d    = 1'b1;
            oe_d    = 1'b1;
            wdata_d = win_wdata;
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? IDLE : RWAIT;
      end
      RWAIT: begin
        // The GPR's registered read output is valid during this state.
        state_d = IDLE;
        if (port_q) begin
          b_rdata_d  = bus.gpr_rdata;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = bus.gpr_rdata;
          a_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      port_q     <= port_d;
      we_q       <= we_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      b_err_q    <= b_err_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.a_gnt       = a_gnt_q;
  assign bus.b_gnt       = b_gnt_q;
  assign bus.b_err       = b_err_q;
  assign bus.a_rvalid    = a_rvalid_q;
  assign bus.b_rvalid    = b_rvalid_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;
  assign bus.gpr_rd      = rd_q;
  assign bus.gpr_wr      = wr_q;
  assign bus.gpr_data_oe = oe_q;
  assign bus.gpr_wdata   = wdata_q;
  assign bus.gpr_address = {{(ADDR_W-4){1'b0}}, addr_q};
endmodule

// File: tb/tb_gpr_access_arbiter.sv
// Bench for gpr_access_arbiter: GPR model, table of single transactions,
// round-robin / reset sequences and random two-port traffic against a scoreboard.
module tb_gpr_access_arbiter;
  localparam int DATA_W    = 14;
  localparam int ADDR_W    = 12;
  localparam int FLAGS_IDX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpr_access_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  gpr_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FLAGS_IDX(FLAGS_IDX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file model: registered read, cleared by reset.
  logic [DATA_W-1:0] gpr_mem [16];
  always @(posedge clk) begin
    if (bus.gpr_wr) gpr_mem[bus.gpr_address[3:0]] <= bus.gpr_wdata;
    if (bus.gpr_rd) bus.gpr_rdata <= gpr_mem[bus.gpr_address[3:0]];
    if (rst) for (int i = 0; i < 16; i++) gpr_mem[i] <= '0;
  end

  // Scoreboard state
  logic [DATA_W-1:0] ref_mem [16];
  logic [DATA_W-1:0] exp_a[$], exp_b[$];
  logic [DATA_W-1:0] hold_a = '0, hold_b = '0;
  bit                gnt_log[$];
  int                a_gnts = 0, b_gnts = 0;
  bit                mon_en = 1'b0;
  logic              m_port, m_we, m_req, m_prot;
  logic [3:0]        m_idx;
  logic [DATA_W-1:0] m_wdata;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.a_gnt || bus.b_gnt) begin
        check("single_gnt", 32'(bus.a_gnt & bus.b_gnt), 0);
        m_port  = bus.b_gnt;
        m_req   = m_port ? bus.b_req   : bus.a_req;
        m_we    = m_port ? bus.b_we    : bus.a_we;
        m_idx   = m_port ? bus.b_idx   : bus.a_idx;
        m_wdata = m_port ? bus.b_wdata : bus.a_wdata;
        m_prot  = m_port && m_we && (m_idx == 4'(FLAGS_IDX));
        check("gnt_with_req", 32'(m_req), 1);
        check("gpr_address", 32'(bus.gpr_address), 32'(m_idx));
        check("gpr_wr", 32'(bus.gpr_wr), 32'(m_we && !m_prot));
        check("gpr_rd", 32'(bus.gpr_rd), 32'(!m_we));
        check("gpr_data_oe", 32'(bus.gpr_data_oe), 32'(m_we && !m_prot));
        check("b_err", 32'(bus.b_err), 32'(m_prot));
        if (m_we && !m_prot) begin
          check("gpr_wdata", 32'(bus.gpr_wdata), 32'(m_wdata));
          ref_mem[m_idx] = m_wdata;
        end
        if (!m_we) begin
          if (m_port) exp_b.push_back(ref_mem[m_idx]);
          else        exp_a.push_back(ref_mem[m_idx]);
        end
        gnt_log.push_back(m_port);
        if (m_port) b_gnts++; else a_gnts++;
        $display("txn t=%0t port=%s we=%0d idx=%0d wdata=0x%0h err=%0d",
                 $time, m_port ? "B" : "A", m_we, m_idx, m_wdata, m_prot);
      end else begin
        check("idle_strobes", {28'd0, bus.gpr_rd, bus.gpr_wr, bus.gpr_data_oe, bus.b_err}, 0);
      end
      check("rd_wr_exclusive", 32'(bus.gpr_rd & bus.gpr_wr), 0);
      if (bus.a_rvalid) begin
        if (exp_a.size() == 0) check("a_rvalid_unexpected", 1, 0);
        else begin
          hold_a = exp_a.pop_front();
          check("a_rdata", 32'(bus.a_rdata), 32'(hold_a));
          $display("rsp t=%0t port=A rdata=0x%0h", $time, bus.a_rdata);
        end
        check("b_rdata_stable", 32'(bus.b_rdata), 32'(hold_b));
      end
      if (bus.b_rvalid) begin
        if (exp_b.size() == 0) check("b_rvalid_unexpected", 1, 0);
        else begin
          hold_b = exp_b.pop_front();
          check("b_rdata", 32'(bus.b_rdata), 32'(hold_b));
          $display("rsp t=%0t port=B rdata=0x%0h", $time, bus.b_rdata);
        end
        check("a_rdata_stable", 32'(bus.a_rdata), 32'(hold_a));
      end
    end
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
      hold_a = '0;
      hold_b = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    end
  end

  // Raise a request, wait for its grant, then drop it just after the grant edge.
  task automatic drive_req(input bit port, input bit we, input logic [3:0] idx,
                           input logic [DATA_W-1:0] wdata);
    bit ok = 1'b0;
    if (port) begin
      bus.b_we = we; bus.b_idx = idx; bus.b_wdata = wdata; bus.b_req = 1'b1;
    end else begin
      bus.a_we = we; bus.a_idx = idx; bus.a_wdata = wdata; bus.a_req = 1'b1;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (port ? bus.b_gnt : bus.a_gnt) ok = 1'b1;
    end
    if (!ok) check("gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (port) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({bus.a_gnt, bus.a_rvalid, bus.b_gnt, bus.b_rvalid, bus.b_err, bus.gpr_rd,
                bus.gpr_wr, bus.gpr_data_oe} | 8'(|bus.a_rdata) | 8'(|bus.b_rdata)
               | 8'(|bus.gpr_address) | 8'(|bus.gpr_wdata));
  endfunction

  typedef struct {
    bit                port;
    bit                we;
    logic [3:0]        idx;
    logic [DATA_W-1:0] wdata;
    bit                exp_wr;
    bit                exp_err;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];
  int   a_issued = 0, b_issued = 0, a_base, b_base, stop_cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1, 4'd3,  14'h1ABC, 1, 0, 14'h0000};
    vecs[1] = '{0, 0, 4'd3,  14'h0000, 0, 0, 14'h1ABC};
    vecs[2] = '{0, 1, 4'd8,  14'h0111, 1, 0, 14'h0000};
    vecs[3] = '{1, 1, 4'd8,  14'h0005, 0, 1, 14'h0000};
    vecs[4] = '{0, 0, 4'd8,  14'h0000, 0, 0, 14'h0111};
    vecs[5] = '{0, 1, 4'd8,  14'h0007, 1, 0, 14'h0000};
    vecs[6] = '{1, 0, 4'd8,  14'h0000, 0, 0, 14'h0007};
    vecs[7] = '{0, 1, 4'd15, 14'h3FFF, 1, 0, 14'h0000};
    vecs[8] = '{1, 0, 4'd15, 14'h0000, 0, 0, 14'h3FFF};

    bus.a_req = 0; bus.a_we = 0; bus.a_idx = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_idx = 0; bus.b_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Table: one isolated transaction per entry with exact-cycle checks.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_fields(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), 32'(vecs[i].port ? bus.b_gnt : bus.a_gnt), 1);
      check($sformatf("vec%0d_gpr_wr", i), 32'(bus.gpr_wr), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d_b_err", i), 32'(bus.b_err), 32'(vecs[i].exp_err));
      @(posedge clk);
      #1 bus.a_req = 1'b0; bus.b_req = 1'b0;
      @(negedge clk);
      if (!vecs[i].we) begin
        check($sformatf("vec%0d_rvalid_early", i),
              32'(vecs[i].port ? bus.b_rvalid : bus.a_rvalid), 0);
        @(negedge clk);
        check($sformatf("vec%0d_rvalid", i), 32'(vecs[i].port ? bus.b_rvalid : bus.a_rvalid), 1);
        check($sformatf("vec%0d_rdata", i),
              32'(vecs[i].port ? bus.b_rdata : bus.a_rdata), 32'(vecs[i].exp_rdata));
      end
    end

    // Both ports hold read requests: grants must alternate starting with A.
    repeat (2) @(negedge clk);
    gnt_log.delete();
    fork
      begin repeat (2) drive_req(0, 0, 4'd3, '0); end
      begin repeat (2) drive_req(1, 0, 4'd15, '0); end
    join
    repeat (4) @(negedge clk);
    check("rr_count", 32'(gnt_log.size()), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check($sformatf("rr_order%0d", i), 32'(gnt_log[i]), 32'(i % 2));

    // B read with reset asserted while the read is in RWAIT.
    @(negedge clk);
    bus.b_we = 0; bus.b_idx = 4'd3; bus.b_req = 1'b1;
    @(negedge clk);
    check("rst_rwait_b_gnt", 32'(bus.b_gnt), 1);
    @(posedge clk);
    #1 bus.b_req = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rwait_outputs", all_outputs(), 0);
    @(negedge clk);
    check("rst_rwait_no_rvalid", 32'(bus.b_rvalid), 0);

    // A granted last, then reset: the next tie must still go to A.
    drive_req(0, 1, 4'd1, 14'h0011);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    gnt_log.delete();
    fork
      drive_req(0, 1, 4'd1, 14'h0101);
      drive_req(1, 1, 4'd2, 14'h0202);
    join
    repeat (3) @(negedge clk);
    check("post_rst_first_gnt_a", 32'(gnt_log.size() > 0 ? gnt_log[0] : 1'b1), 0);

    // Random two-port traffic.
    a_base = a_gnts;
    b_base = b_gnts;
    stop_cyc = cyc + 1000;
    fork
      begin
        while (cyc < stop_cyc) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          drive_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 14'($urandom));
          a_issued++;
        end
      end
      begin
        while (cyc < stop_cyc) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          drive_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 14'($urandom));
          b_issued++;
        end
      end
    join
    repeat (10) @(negedge clk);
    check("rand_a_gnt_count", 32'(a_gnts - a_base), 32'(a_issued));
    check("rand_b_gnt_count", 32'(b_gnts - b_base), 32'(b_issued));
    check("rand_a_pending", 32'(exp_a.size()), 0);
    check("rand_b_pending", 32'(exp_b.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic drive_fields(input vec_t v);
    if (v.port) begin
      bus.b_we = v.we; bus.b_idx = v.idx; bus.b_wdata = v.wdata; bus.b_req = 1'b1;
    end else begin
      bus.a_we = v.we; bus.a_idx = v.idx; bus.a_wdata = v.wdata; bus.a_req = 1'b1;
    end
  endtask
endmodule
